// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, and hands each
// fetched word with its PC to decode over valid/ready. Execute redirects flush stale work.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic [31:0] r_count;
  logic        r_drop;
  logic        r_iv;
  logic        r_err;

  logic w_accept;
  logic w_redir_bad;

  assign w_accept    = (r_state == S_REQ) && imem_req_ready;
  assign w_redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_drop    <= 1'b0;
      r_iv      <= 1'b0;
      r_inst    <= NOP_INST;
      r_inst_pc <= 32'h0;
      r_err     <= 1'b0;
      r_count   <= 32'h0;
    end else if (r_state == S_HALT) begin
      // terminal until reset; redirects and responses are ignored
    end else if (w_redir_bad) begin
      r_state <= S_HALT;
      r_err   <= 1'b1;
      r_iv    <= 1'b0;
      r_inst  <= NOP_INST;
      r_drop  <= 1'b0;
    end else if (redirect_valid) begin
      r_pc   <= redirect_pc;
      r_iv   <= 1'b0;
      r_inst <= NOP_INST;
      case (r_state)
        S_REQ: if (w_accept) begin
          // request for the old address is already out; swallow its response
          r_state <= S_WAIT;
          r_drop  <= 1'b1;
        end
        S_WAIT: if (imem_resp_valid) begin
          r_state <= S_REQ;
          r_drop  <= 1'b0;
        end else begin
          r_drop  <= 1'b1;
        end
        S_HOLD:  r_state <= S_REQ;
        default: ;
      endcase
    end else begin
      case (r_state)
        S_REQ: if (w_accept) r_state <= S_WAIT;
        S_WAIT: if (imem_resp_valid) begin
          if (r_drop) begin
            r_drop  <= 1'b0;
            r_state <= S_REQ;
          end else begin
            r_inst    <= imem_resp_data;
            r_inst_pc <= r_pc;
            r_iv      <= 1'b1;
            r_pc      <= r_pc + 32'd4;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: if (inst_ready) begin
          r_iv    <= 1'b0;
          r_inst  <= NOP_INST;
          r_count <= r_count + 32'd1;
          r_state <= S_REQ;
        end
        default: ;
      endcase
    end
  end

  assign imem_req_valid = rst_n && (r_state == S_REQ);
  assign imem_addr      = r_pc;
  assign inst_valid     = r_iv;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fetch_err      = r_err;
  assign inst_count     = r_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: per-cycle vector table for the fetch/redirect flow,
// then hand sequences for pc wrap, misaligned-redirect halt and reset mid-fetch.
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;
  logic [31:0] inst_count;

  int n_pass = 0;
  int n_total = 0;

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  // one row per cycle: inputs applied this cycle, outputs expected during it
  typedef struct {
    logic        rdy;
    logic        rsv;
    logic [31:0] rsd;
    logic        irdy;
    logic        rdv;
    logic [31:0] rdpc;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[34];

  function automatic logic [31:0] D(input logic [31:0] a);
    return 32'hD000_0000 | a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic rdy, input logic rsv, input logic [31:0] rsd,
                       input logic irdy, input logic rdv, input logic [31:0] rdpc);
    imem_req_ready  = rdy;
    imem_resp_valid = rsv;
    imem_resp_data  = rsd;
    inst_ready      = irdy;
    redirect_valid  = rdv;
    redirect_pc     = rdpc;
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1,0,0,      1,0,0,      1,32'h0,  0,NOP,       0,0};
    tbl[1]  = '{1,1,D(0),   1,0,0,      0,32'h0,  0,NOP,       0,0};
    tbl[2]  = '{1,0,0,      1,0,0,      0,32'h0,  1,D(0),      0,0};
    tbl[3]  = '{1,0,0,      1,0,0,      1,32'h4,  0,NOP,       0,1};
    tbl[4]  = '{1,1,D(4),   1,0,0,      0,32'h4,  0,NOP,       0,1};
    tbl[5]  = '{1,0,0,      1,0,0,      0,32'h8,  1,D(4),      4,1};
    tbl[6]  = '{1,0,0,      1,0,0,      1,32'h8,  0,NOP,       4,2};
    tbl[7]  = '{1,1,D(8),   1,0,0,      0,32'h8,  0,NOP,       4,2};
    tbl[8]  = '{1,0,0,      1,0,0,      0,32'h8,  1,D(8),      8,2};
    tbl[9]  = '{1,0,0,      1,0,0,      1,32'hC,  0,NOP,       8,3};
    tbl[10] = '{1,1,D(12),  0,0,0,      0,32'hC,  0,NOP,       8,3};
    for (int i = 11; i <= 15; i++)
      tbl[i] = '{1,0,0,     0,0,0,      0,32'h10, 1,D(12),    12,3};
    tbl[16] = '{1,0,0,      1,0,0,      0,32'h10, 1,D(12),    12,3};
    tbl[17] = '{1,0,0,      1,0,0,      1,32'h10, 0,NOP,      12,4};
    tbl[18] = '{1,0,0,      1,1,32'h40, 0,32'h10, 0,NOP,      12,4};
    tbl[19] = '{1,0,0,      1,0,0,      0,32'h40, 0,NOP,      12,4};
    tbl[20] = '{1,1,D(16),  1,0,0,      0,32'h40, 0,NOP,      12,4};
    tbl[21] = '{1,0,0,      1,0,0,      1,32'h40, 0,NOP,      12,4};
    tbl[22] = '{1,1,D(64),  1,0,0,      0,32'h40, 0,NOP,      12,4};
    tbl[23] = '{1,0,0,      1,1,32'h80, 0,32'h44, 1,D(64),  32'h40,4};
    tbl[24] = '{0,0,0,      1,1,32'h100,1,32'h80, 0,NOP,       0,4};
    tbl[25] = '{0,0,0,      1,0,0,      1,32'h100,0,NOP,       0,4};
    tbl[26] = '{1,0,0,      1,1,32'h200,1,32'h100,0,NOP,       0,4};
    tbl[27] = '{1,1,D(256), 1,0,0,      0,32'h200,0,NOP,       0,4};
    tbl[28] = '{1,0,0,      1,0,0,      1,32'h200,0,NOP,       0,4};
    tbl[29] = '{1,1,D(512), 1,0,0,      0,32'h200,0,NOP,       0,4};
    tbl[30] = '{1,0,0,      1,0,0,      0,32'h204,1,D(512), 32'h200,4};
    tbl[31] = '{1,0,0,      1,0,0,      1,32'h204,0,NOP,       0,5};
    tbl[32] = '{1,1,D(516), 1,1,32'h300,0,32'h204,0,NOP,       0,5};
    tbl[33] = '{0,0,0,      1,0,0,      1,32'h300,0,NOP,       0,5};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    step();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 0);
    chk("rst_inst_count", inst_count, 0);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].rdy, tbl[i].rsv, tbl[i].rsd, tbl[i].irdy, tbl[i].rdv, tbl[i].rdpc);
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rqv});
      if (tbl[i].e_rqv) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_iv});
      chk($sformatf("v%0d_inst", i), inst, tbl[i].e_inst);
      if (tbl[i].e_iv) chk($sformatf("v%0d_inst_pc", i), inst_pc, tbl[i].e_ipc);
      chk($sformatf("v%0d_count", i), inst_count, tbl[i].e_cnt);
      chk($sformatf("v%0d_err", i), {31'b0, fetch_err}, 0);
      step();
    end

    // pc wrap: redirect to the last word, fetch it, next address wraps to zero
    drive(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    step();
    drive(1, 0, 0, 1, 0, 0);
    #1;
    chk("wrap_req_valid", {31'b0, imem_req_valid}, 1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    drive(0, 1, 32'h1234_5678, 1, 0, 0);
    step();
    drive(0, 0, 0, 1, 0, 0);
    #1;
    chk("wrap_inst_valid", {31'b0, inst_valid}, 1);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", inst, 32'h1234_5678);
    step();
    chk("wrap_next_req", {31'b0, imem_req_valid}, 1);
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_count", inst_count, 6);

    // misaligned redirect halts fetch until reset, even with an accept in the same cycle
    drive(1, 0, 0, 1, 1, 32'h102);
    step();
    drive(1, 0, 0, 1, 0, 0);
    #1;
    chk("halt_err", {31'b0, fetch_err}, 1);
    chk("halt_inst_valid", {31'b0, inst_valid}, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'hBAD0_0000, 1, 1, 32'h40);
      #1;
      chk($sformatf("halt%0d_req_valid", i), {31'b0, imem_req_valid}, 0);
      chk($sformatf("halt%0d_inst_valid", i), {31'b0, inst_valid}, 0);
      chk($sformatf("halt%0d_err", i), {31'b0, fetch_err}, 1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("halt_rst_req_low", {31'b0, imem_req_valid}, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_err", {31'b0, fetch_err}, 0);
    chk("post_rst_req", {31'b0, imem_req_valid}, 1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_count", inst_count, 0);

    // reset while a request is in flight; the late response must not surface
    drive(1, 0, 0, 1, 0, 0);
    step();
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    step();
    rst_n = 1'b1;
    drive(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    step();
    drive(0, 0, 0, 1, 0, 0);
    #1;
    chk("midrst_inst_valid", {31'b0, inst_valid}, 0);
    chk("midrst_inst", inst, NOP);
    chk("midrst_req", {31'b0, imem_req_valid}, 1);
    chk("midrst_addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
